// File: rtl/baudrategen_frac.sv
// Fractional-N baud tick generator: a run-time integer+fraction divisor produces the UART
// oversample tick, plus mid-bit and end-of-bit ticks derived from a sub-tick counter.
module baudrategen_frac #(
    parameter int N_BITS     = 16,
    parameter int F_BITS     = 4,
    parameter int OVERSAMPLE = 16,
    parameter int DEF_INT    = 163,
    parameter int DEF_FRAC   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_enable,
    input  logic              i_load,
    input  logic [N_BITS-1:0] i_div_int,
    input  logic [F_BITS-1:0] i_div_frac,
    input  logic              i_resync,
    output logic              o_tick,
    output logic              o_mid_tick,
    output logic              o_bit_tick,
    output logic              o_cfg_pending
);

    localparam int SUB_W = $clog2(OVERSAMPLE);
    localparam logic [N_BITS-1:0] DEF_INT_C  = (DEF_INT < 2) ? N_BITS'(2) : N_BITS'(DEF_INT);
    localparam logic [F_BITS-1:0] DEF_FRAC_C = F_BITS'(DEF_FRAC);
    localparam logic [SUB_W-1:0]  SUB_MID    = SUB_W'(OVERSAMPLE / 2);

    function automatic logic [N_BITS-1:0] clamp_div(input logic [N_BITS-1:0] v);
        return (v < N_BITS'(2)) ? N_BITS'(2) : v;
    endfunction

    // Active divisor, shadow divisor and pending flag
    logic [N_BITS-1:0] int_q, int_d;
    logic [F_BITS-1:0] frac_q, frac_d;
    logic [N_BITS-1:0] sh_int_q, sh_int_d;
    logic [F_BITS-1:0] sh_frac_q, sh_frac_d;
    logic              pend_q, pend_d;

    // Period timing: counter, latched length of the current period, fractional accumulator
    logic [N_BITS:0]   cnt_q, cnt_d;
    logic [N_BITS:0]   len_q, len_d;
    logic [F_BITS-1:0] acc_q, acc_d;
    logic [SUB_W-1:0]  sub_q, sub_d;

    logic              tick_q, tick_d;
    logic              mid_q, mid_d;
    logic              bit_q, bit_d;

    logic [N_BITS-1:0] load_int;
    logic [N_BITS-1:0] eff_int;
    logic [F_BITS-1:0] eff_frac;
    logic [N_BITS-1:0] rs_int;
    logic [F_BITS-1:0] rs_frac;
    logic [F_BITS:0]   sum;
    logic [SUB_W-1:0]  sub_inc;
    logic              at_end;

    assign load_int = clamp_div(i_div_int);
    // Divisor that governs whatever is computed on this edge: a pending shadow takes priority
    assign eff_int  = pend_q ? sh_int_q  : int_q;
    assign eff_frac = pend_q ? sh_frac_q : frac_q;
    assign rs_int   = i_load ? load_int   : eff_int;
    assign rs_frac  = i_load ? i_div_frac : eff_frac;
    assign sum      = {1'b0, acc_q} + {1'b0, eff_frac};
    assign sub_inc  = sub_q + 1'b1;
    assign at_end   = i_enable && (cnt_q == len_q - 1'b1);

    always_comb begin
        int_d     = int_q;
        frac_d    = frac_q;
        sh_int_d  = sh_int_q;
        sh_frac_d = sh_frac_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        acc_d     = acc_q;
        sub_d     = sub_q;
        tick_d    = 1'b0;
        mid_d     = 1'b0;
        bit_d     = 1'b0;

        if (i_load) begin
            sh_int_d  = load_int;
            sh_frac_d = i_div_frac;
            pend_d    = 1'b1;
        end

        if (i_resync) begin
            int_d  = rs_int;
            frac_d = rs_frac;
            pend_d = 1'b0;
            cnt_d  = '0;
            acc_d  = '0;
            sub_d  = '0;
            len_d  = {1'b0, rs_int};
        end else if (!i_enable) begin
            // Safe to apply while frozen: the running period length is already latched in len_q
            int_d  = eff_int;
            frac_d = eff_frac;
            pend_d = i_load;
        end else if (at_end) begin
            int_d  = eff_int;
            frac_d = eff_frac;
            pend_d = i_load;
            cnt_d  = '0;
            acc_d  = sum[F_BITS-1:0];
            len_d  = {1'b0, eff_int} + {{N_BITS{1'b0}}, sum[F_BITS]};
            sub_d  = sub_inc;
            tick_d = 1'b1;
            mid_d  = (sub_inc == SUB_MID);
            bit_d  = (sub_inc == '0);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            int_q     <= DEF_INT_C;
            frac_q    <= DEF_FRAC_C;
            sh_int_q  <= '0;
            sh_frac_q <= '0;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            len_q     <= {1'b0, DEF_INT_C};
            acc_q     <= '0;
            sub_q     <= '0;
            tick_q    <= 1'b0;
            mid_q     <= 1'b0;
            bit_q     <= 1'b0;
        end else begin
            int_q     <= int_d;
            frac_q    <= frac_d;
            sh_int_q  <= sh_int_d;
            sh_frac_q <= sh_frac_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            acc_q     <= acc_d;
            sub_q     <= sub_d;
            tick_q    <= tick_d;
            mid_q     <= mid_d;
            bit_q     <= bit_d;
        end
    end

    assign o_tick        = tick_q;
    assign o_mid_tick    = mid_q;
    assign o_bit_tick    = bit_q;
    assign o_cfg_pending = pend_q;

endmodule

// File: tb/tb_baudrategen_frac.sv
// Bench for baudrategen_frac: directed period tables, hand-written corner sequences and a
// randomized run, all checked against a period-level reference model.
module tb_baudrategen_frac;

    localparam int DEF_INT = 163;
    localparam int FSCALE  = 16;
    localparam int OS      = 16;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        ld;
    logic [15:0] di;
    logic [3:0]  df;
    logic        rs;
    logic        o_tick;
    logic        o_mid_tick;
    logic        o_bit_tick;
    logic        o_cfg_pending;

    int n_checks = 0;
    int n_fail   = 0;

    baudrategen_frac dut (
        .clock        (clk),
        .reset        (rst_n),
        .i_enable     (en),
        .i_load       (ld),
        .i_div_int    (di),
        .i_div_frac   (df),
        .i_resync     (rs),
        .o_tick       (o_tick),
        .o_mid_tick   (o_mid_tick),
        .o_bit_tick   (o_bit_tick),
        .o_cfg_pending(o_cfg_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles left until the next tick, plus a fractional remainder in 1/16ths
    bit model_on = 1'b0;
    int m_int, m_frac, m_sh_int, m_sh_frac, m_left, m_acc, m_nsub;
    bit m_pend, e_tick, e_mid, e_bit;

    function automatic int clampi(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_step();
        bit apply;
        e_tick = 0;
        e_mid  = 0;
        e_bit  = 0;
        if (!rst_n) begin
            model_on  = 1'b1;
            m_int     = DEF_INT;
            m_frac    = 0;
            m_sh_int  = 0;
            m_sh_frac = 0;
            m_pend    = 0;
            m_left    = DEF_INT;
            m_acc     = 0;
            m_nsub    = 0;
        end else if (rs) begin
            if (ld) begin
                m_int  = clampi(int'(di));
                m_frac = int'(df);
            end else if (m_pend) begin
                m_int  = m_sh_int;
                m_frac = m_sh_frac;
            end
            m_pend = 0;
            m_left = m_int;
            m_acc  = 0;
            m_nsub = 0;
        end else begin
            apply = 0;
            if (en) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    e_tick = 1;
                    m_nsub = (m_nsub + 1) % OS;
                    e_mid  = (m_nsub == OS / 2);
                    e_bit  = (m_nsub == 0);
                    apply  = m_pend;
                end
            end else begin
                apply = m_pend;
            end
            if (apply) begin
                m_int  = m_sh_int;
                m_frac = m_sh_frac;
                m_pend = 0;
            end
            if (en && m_left == 0) begin
                m_acc  = m_acc + m_frac;
                m_left = m_int + ((m_acc >= FSCALE) ? 1 : 0);
                m_acc  = m_acc % FSCALE;
            end
            if (ld) begin
                m_sh_int  = clampi(int'(di));
                m_sh_frac = int'(df);
                m_pend    = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        if (model_on) begin
            #1;
            check("model_tick", 32'(o_tick), 32'(e_tick));
            check("model_mid", 32'(o_mid_tick), 32'(e_mid));
            check("model_bit", 32'(o_bit_tick), 32'(e_bit));
            check("model_pending", 32'(o_cfg_pending), 32'(m_pend));
        end
    end

    // All stimulus tasks start and end on a falling edge
    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_tick", 32'(o_tick), 0);
        check("reset_pending", 32'(o_cfg_pending), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input int vi, input int vf);
        ld = 1'b1;
        di = 16'(vi);
        df = 4'(vf);
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic pulse_resync(input bit with_load, input int vi);
        rs = 1'b1;
        ld = with_load;
        di = 16'(vi);
        df = 4'd0;
        @(negedge clk);
        rs = 1'b0;
        ld = 1'b0;
    endtask

    task automatic wait_tick(input int max_edges, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_tick && n < max_edges);
        if (!o_tick) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: no o_tick within %0d edges, expected one (t=%0t)",
                     max_edges, $time);
        end
    endtask

    typedef struct {
        int di;
        int df;
        int nticks;
        int exp_cycles;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n;
        int total;
        int seen;

        vecs[0] = '{163, 0, 16, 2608};
        vecs[1] = '{163, 8, 32, 5232};
        vecs[2] = '{54,  0,  8, 432};
        vecs[3] = '{1,   0, 10, 20};
        vecs[4] = '{0,   0,  4, 8};
        vecs[5] = '{10,  4, 32, 328};
        vecs[6] = '{5,  15, 16, 95};
        vecs[7] = '{2,   1, 16, 33};

        rst_n = 1'b0;
        en    = 1'b1;
        ld    = 1'b0;
        rs    = 1'b0;
        di    = '0;
        df    = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Default divisor: first tick at edge 163, mid on 8th tick, bit on 16th
        wait_tick(400, n);
        check("t1_first_tick", n, 163);
        for (int k = 2; k <= 16; k++) begin
            wait_tick(400, n);
            check("t1_period", n, 163);
            if (k == 8)  check("t1_mid_8th", 32'(o_mid_tick), 1);
            if (k == 16) check("t1_bit_16th", 32'(o_bit_tick), 1);
        end

        // Mid-period load keeps the running period, then switches; int=1 clamps to 2
        do_reset();
        idle(50);
        pulse_load(54, 0);
        check("t3_pending", 32'(o_cfg_pending), 1);
        wait_tick(400, n);
        check("t3_old_period", n, 112);
        check("t3_applied", 32'(o_cfg_pending), 0);
        wait_tick(400, n);
        check("t3_new_period", n, 54);
        pulse_load(1, 0);
        wait_tick(400, n);
        check("t3_finish_54", n, 53);
        wait_tick(400, n);
        check("t3_clamp_a", n, 2);
        wait_tick(400, n);
        check("t3_clamp_b", n, 2);

        // Freeze at counter 100 for 50 cycles
        do_reset();
        idle(100);
        en   = 1'b0;
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (o_tick) seen++;
        end
        en = 1'b1;
        check("t4_no_ticks", seen, 0);
        wait_tick(400, n);
        check("t4_resume", n, 63);

        // Resync at counter 80 with sub=5
        do_reset();
        for (int k = 0; k < 5; k++) wait_tick(400, n);
        idle(80);
        pulse_resync(1'b0, 0);
        check("t5_rs_quiet", 32'(o_tick), 0);
        wait_tick(400, n);
        check("t5_after_rs", n, 163);
        for (int k = 2; k <= 8; k++) wait_tick(400, n);
        check("t5_mid_8th", 32'(o_mid_tick), 1);
        // Resync landing on the edge a tick was due
        idle(162);
        pulse_resync(1'b0, 0);
        check("t5_suppressed", 32'(o_tick), 0);
        wait_tick(400, n);
        check("t5_after_supp", n, 163);

        // Resync together with load applies the new divisor at once
        do_reset();
        idle(20);
        pulse_resync(1'b1, 30);
        check("rsld_pending", 32'(o_cfg_pending), 0);
        wait_tick(400, n);
        check("rsld_period", n, 30);
        // A second load before the boundary overwrites the shadow
        pulse_load(40, 0);
        pulse_load(20, 0);
        wait_tick(400, n);
        check("overwrite_old", n, 28);
        wait_tick(400, n);
        check("overwrite_new", n, 20);

        // Reset with a pending load
        do_reset();
        idle(30);
        pulse_load(54, 0);
        idle(10);
        do_reset();
        check("t6_mid", 32'(o_mid_tick), 0);
        wait_tick(400, n);
        check("t6_first", n, 163);
        wait_tick(400, n);
        check("t6_second", n, 163);

        // Table of divisors: load during the first default period, measure after it applies
        for (int v = 0; v < 8; v++) begin
            do_reset();
            pulse_load(vecs[v].di, vecs[v].df);
            check("tbl_pending", 32'(o_cfg_pending), 1);
            wait_tick(400, n);
            check("tbl_apply_edge", n, 162);
            check("tbl_applied", 32'(o_cfg_pending), 0);
            total = 0;
            for (int k = 0; k < vecs[v].nticks; k++) begin
                wait_tick(400, n);
                total += n;
            end
            check("tbl_cycles", total, vecs[v].exp_cycles);
        end

        // Randomized traffic; the reference model checks every cycle
        do_reset();
        pulse_load(4, 3);
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom % 500) != 0;
            en    = ($urandom % 6) != 0;
            ld    = ($urandom % 20) == 0;
            di    = 16'($urandom_range(0, 9));
            df    = 4'($urandom);
            rs    = ($urandom % 80) == 0;
            @(negedge clk);
        end
        rst_n = 1'b1;
        en    = 1'b1;
        ld    = 1'b0;
        rs    = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
